// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - registered execute stage: single-cycle ALU ops plus iterative shift-add multiply
module execute_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             flush,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             valid_o,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;
    logic [SHW-1:0]   shamt;

    assign shamt    = SrcB[SHW-1:0];
    assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SLL:  alu_res = SrcA << shamt;
            OP_SRL:  alu_res = SrcA >> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && !flush) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_d  = SrcA;
                        mplier_d = SrcB;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    // Fixed-latency: always WIDTH steps, even with a zero multiplier.
                    if (count_q == LAST_STEP) begin
                        result_d = acc_next;
                        zero_d   = (acc_next == '0);
                        valid_d  = 1'b1;
                        count_d  = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign busy      = (state_q == MUL);
    assign valid_o   = valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - directed self-checking bench for execute_unit
module tb_execute_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        flush;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        valid_o;
    logic [31:0] ALUResult;
    logic        Zero;

    int n_checks = 0;
    int n_errors = 0;

    execute_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .flush      (flush),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .valid_o    (valid_o),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i    = v;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
    endtask

    // Accept a mul now and walk through its WIDTH busy cycles, then check the product.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(1'b1, 3'b010, a, b);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        for (int i = 1; i <= 32; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_novalid"}, {31'd0, valid_o}, 32'd0);
            tick();
        end
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_res"}, ALUResult, exp);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_res", ALUResult, 32'd0);
        check("rst_zero", {31'd0, Zero}, 32'd1);
        rst = 1'b0;

        // Back-to-back add then sub.
        drive(1'b1, 3'b000, 32'd5, 32'd3);
        tick();
        check("add_valid", {31'd0, valid_o}, 32'd1);
        check("add_res", ALUResult, 32'h8);
        check("add_zero", {31'd0, Zero}, 32'd0);
        check("add_busy", {31'd0, busy}, 32'd0);
        drive(1'b1, 3'b001, 32'd5, 32'd5);
        tick();
        check("sub_valid", {31'd0, valid_o}, 32'd1);
        check("sub_res", ALUResult, 32'h0);
        check("sub_zero", {31'd0, Zero}, 32'd1);
        check("sub_busy", {31'd0, busy}, 32'd0);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        check("idle_valid", {31'd0, valid_o}, 32'd0);
        check("idle_hold", ALUResult, 32'h0);

        // mul 7*6 with an add presented throughout busy; the add is taken at T+33.
        drive(1'b1, 3'b010, 32'd7, 32'd6);
        tick();
        drive(1'b1, 3'b000, 32'd1, 32'd1);
        for (int i = 1; i <= 32; i++) begin
            check("mul7_busy", {31'd0, busy}, 32'd1);
            check("mul7_novalid", {31'd0, valid_o}, 32'd0);
            tick();
        end
        check("mul7_valid", {31'd0, valid_o}, 32'd1);
        check("mul7_res", ALUResult, 32'h2A);
        check("mul7_zero", {31'd0, Zero}, 32'd0);
        check("mul7_idle", {31'd0, busy}, 32'd0);
        tick();
        check("add_after_valid", {31'd0, valid_o}, 32'd1);
        check("add_after_res", ALUResult, 32'h2);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        check("add_after_once", {31'd0, valid_o}, 32'd0);

        run_mul("mulff", 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE);
        tick();

        // Flush at T+10 of a mul.
        drive(1'b1, 3'b010, 32'd3, 32'd3);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_hold", ALUResult, 32'hFFFF_FFFE);
        for (int i = 0; i < 25; i++) begin
            check("flush_quiet", {31'd0, valid_o}, 32'd0);
            tick();
        end

        // Flush coinciding with valid_i wins.
        drive(1'b1, 3'b000, 32'd1, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        check("flushv_valid", {31'd0, valid_o}, 32'd0);
        check("flushv_busy", {31'd0, busy}, 32'd0);
        check("flushv_hold", ALUResult, 32'hFFFF_FFFE);

        // Reset at T+5 of a mul.
        drive(1'b1, 3'b010, 32'd7, 32'd6);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmul_busy", {31'd0, busy}, 32'd0);
        check("rstmul_valid", {31'd0, valid_o}, 32'd0);
        check("rstmul_res", ALUResult, 32'd0);
        check("rstmul_zero", {31'd0, Zero}, 32'd1);

        // Shifts and logic, back to back.
        drive(1'b1, 3'b110, 32'h1, 32'h21);
        tick();
        check("sll_res", ALUResult, 32'h2);
        check("sll_valid", {31'd0, valid_o}, 32'd1);
        drive(1'b1, 3'b111, 32'h8000_0000, 32'd31);
        tick();
        check("srl_res", ALUResult, 32'h1);
        drive(1'b1, 3'b101, 32'hFFFF_0000, 32'h0F0F_0F0F);
        tick();
        check("xor_res", ALUResult, 32'hF0F0_0F0F);
        drive(1'b1, 3'b011, 32'hFF00_FF00, 32'h0FF0_0FF0);
        tick();
        check("and_res", ALUResult, 32'h0F00_0F00);
        drive(1'b1, 3'b100, 32'hF000_0000, 32'h0000_000F);
        tick();
        check("or_res", ALUResult, 32'hF000_000F);
        drive(1'b0, 3'b000, 32'd0, 32'd0);

        // Flush on the final mul step discards the product.
        drive(1'b1, 3'b010, 32'd7, 32'd6);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (31) tick();
        check("lastflush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("lastflush_valid", {31'd0, valid_o}, 32'd0);
        check("lastflush_busy", {31'd0, busy}, 32'd0);
        check("lastflush_hold", ALUResult, 32'hF000_000F);
        tick();
        check("lastflush_quiet", {31'd0, valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/execute_unit.md
# execute_unit

Registered execute-stage datapath that consumes `ALUControl` from the control-unit decoder and the operand pair from the ID/EX register. It produces `ALUResult` and `Zero` for the EX/MEM register. Add, subtract and the logic and shift operations complete in one cycle. Multiply (`muli` and R-type mul) runs as an iterative shift-add sequence, and the block stalls the upstream pipeline with `busy` until the product is ready.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be a power of two, at least 8.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  operation present on the inputs this cycle.
- `flush`  in  1  synchronous kill of the in-flight and presented operation.
- `ALUControl`  in  3  operation select:
  - 000 add, 001 sub, 010 mul, 011 and
  - 100 or, 101 xor, 110 sll, 111 srl
- `SrcA`  in  WIDTH  first operand; multiplicand for mul.
- `SrcB`  in  WIDTH  second operand; multiplier for mul, shift amount for sll/srl.
- `busy`  out  1  multiply in progress; upstream must hold its inputs and stall.
- `valid_o`  out  1  `ALUResult` and `Zero` are valid this cycle (one-cycle pulse per operation).
- `ALUResult`  out  WIDTH  registered result.
- `Zero`  out  1  registered `ALUResult == 0`.

## Operation
- **Accept:** an operation is accepted when `valid_i && !busy && !flush`. Inputs presented while `busy` is high are ignored.
- **States:**
  - IDLE. A non-mul op is accepted: `ALUResult` is registered and `valid_o` is set; the block stays in IDLE. A mul op is accepted: load multiplicand = `SrcA`, multiplier = `SrcB`, acc = 0, count = 0; go to MUL.
  - MUL. Each cycle: if multiplier[0] is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1 (logical), count++. On the step where count == WIDTH-1, register acc_next into `ALUResult`, set `valid_o`, and return to IDLE.
- **Arithmetic:**
  - add/sub wrap modulo 2^WIDTH; no carry or overflow outputs.
  - mul returns the low WIDTH bits of the unsigned product. These equal the two's-complement low bits for signed operands.
  - sll/srl shift `SrcA` by `SrcB[log2(WIDTH)-1:0]`, with zero fill. Upper `SrcB` bits are ignored.
- **Held values:** `Zero` is computed from the value written into `ALUResult`. `ALUResult` and `Zero` hold their last values when `valid_o` is low.
- **`busy`:** high exactly while the state is MUL.
- **`flush`:** state goes to IDLE, count clears, and `valid_o` is 0 next cycle. `ALUResult` and `Zero` are not updated. If `flush` coincides with `valid_i`, flush wins and nothing is accepted. If `flush` arrives on the final MUL step, the product is discarded.
- **`rst`:** state goes to IDLE and all internal registers clear. Outputs are `busy=0`, `valid_o=0`, `ALUResult=0`, `Zero=1`. Reset takes priority over `flush` and `valid_i`. Reset mid-multiply abandons the operation.
- **Unknown inputs:** `ALUControl` values are fully decoded, so there is no illegal-op state.

## Timing
- Accept in cycle T. For a non-mul op, `valid_o` is high in T+1 and `busy` stays low, so back-to-back non-mul ops deliver one result per cycle.
- Accept a mul in cycle T:
  - `busy` is high in cycles T+1 through T+WIDTH.
  - `valid_o` and the product appear in T+WIDTH+1.
  - `busy` is low in T+WIDTH+1, so a new op may be accepted that same cycle; its result follows in T+WIDTH+2.
- Latency is fixed: mul always takes WIDTH iterations, with no early termination on a zero multiplier.
- No combinational path from inputs to outputs. `busy` derives from registered state only.

## Test plan
- Reset, then `add` 0x0000_0005 + 0x0000_0003, followed next cycle by `sub` 5 − 5 -> `valid_o` in consecutive cycles with 0x0000_0008 (`Zero=0`) then 0x0000_0000 (`Zero=1`); `busy` never high.
- `mul` 0x0000_0007 × 0x0000_0006 accepted at T -> `busy` high T+1..T+32, `ALUResult`=0x0000_002A with `valid_o` at T+33 only. Also 0xFFFF_FFFF × 0x0000_0002 -> 0xFFFF_FFFE.
- While `busy`, drive `valid_i` with `add` 1+1 -> ignored, no extra `valid_o`. Present the same add at T+33 -> 0x0000_0002 at T+34.
- `flush` at T+10 of a mul -> `busy` low at T+11, no `valid_o`, `ALUResult` keeps its prior value. `flush` together with `valid_i` -> nothing accepted.
- `rst` asserted at T+5 of a mul -> next cycle `busy=0`, `valid_o=0`, `ALUResult`=0, `Zero=1`.
- `sll` 0x0000_0001 by `SrcB`=0x0000_0021 -> 0x0000_0002 (only 5 LSBs used). `srl` 0x8000_0000 by 31 -> 0x0000_0001. `xor` 0xFFFF_0000 ^ 0x0F0F_0F0F -> 0xF0F0_0F0F.
